mux_rr_arbiter: RTL

// - Parametrised N-channel, W-bit multiplexer with built-in arbitration and a

---
 rtl/mux_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: N-channel W-bit stream merger with round-robin or fixed
// priority arbitration feeding a single registered valid/ready output slot.
module mux_rr_arbiter #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = 0,
  localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_out_data;
  logic [CW-1:0]      r_out_chan;
  logic [CW-1:0]      r_rr_ptr;

  logic               w_any;
  logic               w_load_en;
  logic               w_xfer;
  logic               w_lo_found;
  logic [CW-1:0]      w_lo_idx;
  logic               w_hi_found;
  logic [CW-1:0]      w_hi_idx;
  logic [CW-1:0]      w_winner;
  logic [CW-1:0]      w_next_ptr;
  logic [WIDTH-1:0]   w_sel_data;

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

  // Slot can take a beat when empty or being drained; nothing is granted in reset.
  assign w_any     = |in_valid;
  assign w_load_en = rst_n & (~out_valid | out_ready);
  assign w_xfer    = w_load_en & w_any;

  // Lowest valid index overall, and lowest valid index at or above rr_ptr.
  always_comb begin
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = CW'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = CW'(i);
        end
      end
    end
  end

  // Winner: fixed priority takes the lowest index; round-robin wraps past the top.
  always_comb begin
    w_winner = '0;
    if (CHANNELS > 1) begin
      if (MODE == 1) begin
        w_winner = w_lo_idx;
      end else if (w_hi_found) begin
        w_winner = w_hi_idx;
      end else if (w_lo_found) begin
        w_winner = w_lo_idx;
      end
    end
  end

  // Pointer advances to the channel after the winner, modulo CHANNELS.
  always_comb begin
    w_next_ptr = '0;
    if (w_winner != CW'(CHANNELS - 1)) begin
      w_next_ptr = w_winner + CW'(1);
    end
  end

  // One-hot grant decode and data select driven only by the winner index.
  always_comb begin
    in_ready   = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (w_winner == CW'(i)) begin
        in_ready[i] = w_xfer;
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot FSM with registered data/channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_xfer) begin
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (!w_xfer && out_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_chan <= w_winner;
        if (MODE == 0) begin
          r_rr_ptr <= w_next_ptr;
        end
      end
    end
  end

endmodule
